// File: rtl/rom_loader_wide.sv
// rom_loader_wide: host-to-ioctl download bridge. Each HOST_DW-bit word taken from
// the ctrl module over a 4-phase req/ack handshake is split into LANES ioctl writes
// of OUT_DW bits. Writes are spaced by WR_GAP idle cycles and limited to the file
// size latched at download start. A drop of the download window aborts the transfer.
//
// state | meaning
// IDLE  | waiting for a host word (req high, ack low, download active)
// EMIT  | issue one lane as an ioctl write, or flag overflow if beyond the limit
// GAP   | forced idle cycles between consecutive write strobes
// WAIT  | all lanes issued, waiting for the host to drop req
module rom_loader_wide #(
    parameter int HOST_DW    = 32,
    parameter int OUT_DW     = 8,
    parameter int AW         = 27,
    parameter int WR_GAP     = 1,
    parameter int BIG_ENDIAN = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [HOST_DW-1:0] host_bootdata,
    input  logic               host_bootdata_req,
    input  logic               host_bootdata_download,
    output logic               host_bootdata_ack,
    input  logic [23:0]        host_bootdata_size,
    input  logic [2:0]         host_file_type,
    output logic               ioctl_download,
    output logic [15:0]        ioctl_index,
    output logic               ioctl_wr,
    output logic [AW-1:0]      ioctl_addr,
    output logic [OUT_DW-1:0]  ioctl_dout,
    output logic               loader_done,
    output logic               loader_overflow
);

    localparam int LANES = HOST_DW / OUT_DW;
    localparam int STEP  = OUT_DW / 8;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_GAP,
        S_WAIT
    } state_t;

    state_t              state_q;
    logic                dl_q;
    logic                ack_q;
    logic                wr_q;
    logic                download_q;
    logic                overflow_q;
    logic                done_q;
    logic [AW-1:0]       addr_q;
    logic [OUT_DW-1:0]   dout_q;
    logic [15:0]         index_q;
    logic [HOST_DW-1:0]  word_q;
    logic [LW-1:0]       lane_q;
    logic [2:0]          gap_q;
    // Byte count carries one extra bit over the limit so count+STEP never wraps.
    logic [25:0]         count_q;
    logic [24:0]         limit_q;

    logic                start_d;
    logic                fall_d;
    logic                fits_d;
    logic                last_lane_d;
    logic [OUT_DW-1:0]   lane_dout_d;
    logic [15:0]         index_d;
    logic [HOST_DW-1:0]  word_shift_d;

    // Edge detection, limit check, lane selection and file-type decode.
    always_comb begin
        start_d     = host_bootdata_download & ~dl_q;
        fall_d      = ~host_bootdata_download & dl_q;
        fits_d      = (count_q + 26'(STEP)) <= {1'b0, limit_q};
        last_lane_d = (lane_q == LW'(LANES - 1));
        // The word register shifts after every lane, so lane 0 position always holds the next lane.
        if (BIG_ENDIAN != 0) begin
            lane_dout_d  = word_q[HOST_DW-1 -: OUT_DW];
            word_shift_d = word_q << OUT_DW;
        end else begin
            lane_dout_d  = word_q[OUT_DW-1:0];
            word_shift_d = word_q >> OUT_DW;
        end
        case (host_file_type)
            3'b111:  index_d = 16'h0000;
            3'b010:  index_d = 16'h001F;
            default: index_d = 16'h005F;
        endcase
    end

    // Download session control, handshake and lane-unpacking FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dl_q       <= 1'b0;
            ack_q      <= 1'b0;
            wr_q       <= 1'b0;
            download_q <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b1;
            addr_q     <= '0;
            dout_q     <= '0;
            index_q    <= '0;
            word_q     <= '0;
            lane_q     <= '0;
            gap_q      <= '0;
            count_q    <= '0;
            limit_q    <= '0;
        end else begin
            dl_q <= host_bootdata_download;
            wr_q <= 1'b0;
            if (!host_bootdata_req) begin
                ack_q <= 1'b0;
            end
            // Address advances the cycle after its strobe; count was already advanced in EMIT.
            if (wr_q) begin
                addr_q <= addr_q + AW'(STEP);
                if (count_q == {1'b0, limit_q}) begin
                    done_q <= 1'b1;
                end
            end
            if (fall_d) begin
                state_q    <= S_IDLE;
                ack_q      <= 1'b0;
                done_q     <= 1'b1;
                download_q <= 1'b0;
            end else if (start_d) begin
                state_q    <= S_IDLE;
                addr_q     <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
                done_q     <= 1'b0;
                download_q <= 1'b1;
                index_q    <= index_d;
                limit_q    <= {1'b0, host_bootdata_size} + 25'd1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (host_bootdata_req && download_q && !ack_q) begin
                            word_q  <= host_bootdata;
                            ack_q   <= 1'b1;
                            lane_q  <= '0;
                            state_q <= S_EMIT;
                        end
                    end
                    S_EMIT: begin
                        if (fits_d) begin
                            wr_q    <= 1'b1;
                            dout_q  <= lane_dout_d;
                            count_q <= count_q + 26'(STEP);
                        end else begin
                            overflow_q <= 1'b1;
                        end
                        word_q <= word_shift_d;
                        if (last_lane_d) begin
                            state_q <= S_WAIT;
                        end else begin
                            lane_q <= lane_q + LW'(1);
                            if (WR_GAP == 0) begin
                                state_q <= S_EMIT;
                            end else begin
                                gap_q   <= 3'(WR_GAP - 1);
                                state_q <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_q == 3'd0) begin
                            state_q <= S_EMIT;
                        end else begin
                            gap_q <= gap_q - 3'd1;
                        end
                    end
                    S_WAIT: begin
                        if (!host_bootdata_req || !ack_q) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign host_bootdata_ack = ack_q;
    assign ioctl_download    = download_q;
    assign ioctl_index       = index_q;
    assign ioctl_wr          = wr_q;
    assign ioctl_addr        = addr_q;
    assign ioctl_dout        = dout_q;
    assign loader_done       = done_q;
    assign loader_overflow   = overflow_q;

endmodule

// File: tb/tb_rom_loader_wide.sv
// Bench for rom_loader_wide: four instances with different widths, lane orders and
// write gaps share one host stimulus; every write is logged and compared against a
// byte-stream model of the download.
module tb_rom_loader_wide;

    localparam int ND = 4;
    localparam int AW = 27;

    typedef struct {
        int          d;
        int unsigned a;
        int unsigned v;
        int unsigned c;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bootdata;
    logic        req;
    logic        download;
    logic [23:0] size;
    logic [2:0]  ftype;

    logic [ND-1:0] ack, wr, dlo, done, ovf;
    logic [15:0]   idx  [ND];
    logic [AW-1:0] addr [ND];
    logic [15:0]   dout [ND];
    logic [7:0]    dout0, dout3;
    logic [15:0]   dout1, dout2;

    int c_out [ND] = '{8, 16, 16, 8};
    int c_be  [ND] = '{1, 1, 0, 0};
    int c_gap [ND] = '{1, 1, 3, 0};

    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    ev_t         ev_q[$];
    int          ack_rise [ND] = '{default: 0};
    logic [ND-1:0] ack_prev = '0;

    int unsigned words_q[$];
    int          ev_base;
    int          rise_base [ND];
    int unsigned cur_size;
    logic [15:0] cur_idx;

    always #5 clk = ~clk;

    rom_loader_wide #(.HOST_DW(32), .OUT_DW(8), .AW(AW), .WR_GAP(1), .BIG_ENDIAN(1)) u0 (
        .clk(clk), .reset(reset), .host_bootdata(bootdata), .host_bootdata_req(req),
        .host_bootdata_download(download), .host_bootdata_ack(ack[0]), .host_bootdata_size(size),
        .host_file_type(ftype), .ioctl_download(dlo[0]), .ioctl_index(idx[0]), .ioctl_wr(wr[0]),
        .ioctl_addr(addr[0]), .ioctl_dout(dout0), .loader_done(done[0]), .loader_overflow(ovf[0]));
    rom_loader_wide #(.HOST_DW(32), .OUT_DW(16), .AW(AW), .WR_GAP(1), .BIG_ENDIAN(1)) u1 (
        .clk(clk), .reset(reset), .host_bootdata(bootdata), .host_bootdata_req(req),
        .host_bootdata_download(download), .host_bootdata_ack(ack[1]), .host_bootdata_size(size),
        .host_file_type(ftype), .ioctl_download(dlo[1]), .ioctl_index(idx[1]), .ioctl_wr(wr[1]),
        .ioctl_addr(addr[1]), .ioctl_dout(dout1), .loader_done(done[1]), .loader_overflow(ovf[1]));
    rom_loader_wide #(.HOST_DW(32), .OUT_DW(16), .AW(AW), .WR_GAP(3), .BIG_ENDIAN(0)) u2 (
        .clk(clk), .reset(reset), .host_bootdata(bootdata), .host_bootdata_req(req),
        .host_bootdata_download(download), .host_bootdata_ack(ack[2]), .host_bootdata_size(size),
        .host_file_type(ftype), .ioctl_download(dlo[2]), .ioctl_index(idx[2]), .ioctl_wr(wr[2]),
        .ioctl_addr(addr[2]), .ioctl_dout(dout2), .loader_done(done[2]), .loader_overflow(ovf[2]));
    rom_loader_wide #(.HOST_DW(32), .OUT_DW(8), .AW(AW), .WR_GAP(0), .BIG_ENDIAN(0)) u3 (
        .clk(clk), .reset(reset), .host_bootdata(bootdata), .host_bootdata_req(req),
        .host_bootdata_download(download), .host_bootdata_ack(ack[3]), .host_bootdata_size(size),
        .host_file_type(ftype), .ioctl_download(dlo[3]), .ioctl_index(idx[3]), .ioctl_wr(wr[3]),
        .ioctl_addr(addr[3]), .ioctl_dout(dout3), .loader_done(done[3]), .loader_overflow(ovf[3]));

    assign dout[0] = {8'h00, dout0};
    assign dout[1] = dout1;
    assign dout[2] = dout2;
    assign dout[3] = {8'h00, dout3};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_ev(int d, int unsigned a, int unsigned v);
        ev_t e;
        e.d = d;
        e.a = a;
        e.v = v;
        e.c = cyc;
        ev_q.push_back(e);
    endfunction

    // Write logger and ack-pulse counter, sampled mid-cycle.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (wr[d]) push_ev(d, 32'(addr[d]), 32'(dout[d]));
            if (ack[d] && !ack_prev[d]) ack_rise[d] = ack_rise[d] + 1;
        end
        ack_prev = ack;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] idx_of(input logic [2:0] t);
        if (t == 3'b111) return 16'h0000;
        if (t == 3'b010) return 16'h001F;
        return 16'h005F;
    endfunction

    task automatic check_reset(input string tag);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s d%0d ack", tag, d), 32'(ack[d]), 32'd0);
            chk($sformatf("%s d%0d wr", tag, d), 32'(wr[d]), 32'd0);
            chk($sformatf("%s d%0d dl", tag, d), 32'(dlo[d]), 32'd0);
            chk($sformatf("%s d%0d ovf", tag, d), 32'(ovf[d]), 32'd0);
            chk($sformatf("%s d%0d done", tag, d), 32'(done[d]), 32'd1);
            chk($sformatf("%s d%0d addr", tag, d), 32'(addr[d]), 32'd0);
            chk($sformatf("%s d%0d dout", tag, d), 32'(dout[d]), 32'd0);
            chk($sformatf("%s d%0d idx", tag, d), 32'(idx[d]), 32'd0);
        end
    endtask

    task automatic wait_acks(input string tag, input bit lvl);
        int n;
        n = 0;
        while (n < 300 && !((lvl && (&ack)) || (!lvl && ack == '0))) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s ack wait %0d", tag, lvl), 32'(n < 300), 32'd1);
    endtask

    task automatic start_session(input logic [2:0] t, input int unsigned sz);
        words_q.delete();
        ev_base  = ev_q.size();
        cur_size = sz;
        cur_idx  = idx_of(t);
        for (int d = 0; d < ND; d++) rise_base[d] = ack_rise[d];
        ftype    = t;
        size     = 24'(sz);
        download = 1'b1;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("start d%0d idx", d), 32'(idx[d]), 32'(cur_idx));
            chk($sformatf("start d%0d dl", d), 32'(dlo[d]), 32'd1);
            chk($sformatf("start d%0d done", d), 32'(done[d]), 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic send_word(input int unsigned w, input int hold);
        int na [ND];
        bootdata = w;
        words_q.push_back(w);
        req = 1'b1;
        if (hold == 0) begin
            wait_acks("send", 1'b1);
            req = 1'b0;
            wait_acks("send", 1'b0);
        end else begin
            for (int d = 0; d < ND; d++) na[d] = 0;
            repeat (hold) begin
                @(negedge clk);
                for (int d = 0; d < ND; d++) if (ack[d]) na[d]++;
            end
            req = 1'b0;
            repeat (5) begin
                @(negedge clk);
                for (int d = 0; d < ND; d++) if (ack[d]) na[d]++;
            end
            for (int d = 0; d < ND; d++)
                chk($sformatf("hold d%0d ack cycles", d), 32'(na[d]), 32'(hold));
        end
    endtask

    // Reference: the file is a byte stream of lanes in host order, truncated at size+1 bytes.
    task automatic check_session(input string tag);
        int unsigned exp_a[$], exp_v[$], exp_w[$];
        ev_t         got[$];
        int unsigned limit, cnt, v;
        int          step, lanes, sh;
        bit          eovf;
        for (int d = 0; d < ND; d++) begin
            exp_a.delete(); exp_v.delete(); exp_w.delete(); got.delete();
            limit = cur_size + 1;
            cnt   = 0;
            eovf  = 1'b0;
            step  = c_out[d] / 8;
            lanes = 32 / c_out[d];
            for (int w = 0; w < words_q.size(); w++) begin
                for (int k = 0; k < lanes; k++) begin
                    sh = (c_be[d] != 0) ? 32 - c_out[d] * (k + 1) : c_out[d] * k;
                    v  = (words_q[w] >> sh) & ((32'd1 << c_out[d]) - 1);
                    if (cnt + step <= limit) begin
                        exp_a.push_back(cnt);
                        exp_v.push_back(v);
                        exp_w.push_back(w);
                        cnt += step;
                    end else begin
                        eovf = 1'b1;
                    end
                end
            end
            for (int i = ev_base; i < ev_q.size(); i++)
                if (ev_q[i].d == d) got.push_back(ev_q[i]);
            chk($sformatf("%s d%0d nwr", tag, d), 32'(got.size()), 32'(exp_a.size()));
            for (int i = 0; i < exp_a.size() && i < got.size(); i++) begin
                chk($sformatf("%s d%0d wr%0d addr", tag, d, i), got[i].a, exp_a[i]);
                chk($sformatf("%s d%0d wr%0d data", tag, d, i), got[i].v, exp_v[i]);
                if (i > 0 && exp_w[i] == exp_w[i-1])
                    chk($sformatf("%s d%0d wr%0d spacing", tag, d, i), got[i].c - got[i-1].c,
                        32'(c_gap[d] + 1));
            end
            chk($sformatf("%s d%0d ovf", tag, d), 32'(ovf[d]), 32'(eovf));
            chk($sformatf("%s d%0d done", tag, d), 32'(done[d]), 32'(cnt == limit));
            chk($sformatf("%s d%0d ack pulses", tag, d), 32'(ack_rise[d] - rise_base[d]),
                32'(words_q.size()));
            chk($sformatf("%s d%0d idx held", tag, d), 32'(idx[d]), 32'(cur_idx));
        end
    endtask

    task automatic end_session(input string tag);
        repeat (40) @(negedge clk);
        check_session(tag);
        download = 1'b0;
        repeat (2) @(negedge clk);
        chk($sformatf("%s end done", tag), 32'(done), 32'hF);
        chk($sformatf("%s end dl", tag), 32'(dlo), 32'h0);
    endtask

    task automatic wait_two_strobes(input string tag);
        int seen, n;
        seen = 0;
        n    = 0;
        while (seen < 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (wr[0]) seen++;
        end
        chk($sformatf("%s two strobes", tag), 32'(seen), 32'd2);
    endtask

    initial begin
        int rb, nw;
        reset    = 1'b1;
        req      = 1'b0;
        download = 1'b0;
        bootdata = '0;
        size     = '0;
        ftype    = 3'b111;
        repeat (2) @(negedge clk);
        check_reset("rst_hold");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("rst_idle");

        // Size limit of 6 bytes cuts the second word short.
        start_session(3'b111, 5);
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
        end_session("t1");

        // Wide lane order.
        start_session(3'b010, 100);
        send_word(32'hAABBCCDD, 0);
        end_session("t2");

        // File type change after start must not affect the index.
        start_session(3'b001, 100);
        ftype = 3'b111;
        send_word($urandom, 0);
        end_session("t4");

        // Long req hold: one word only, next word continues the address.
        start_session(3'b111, 200);
        send_word($urandom, 20);
        send_word($urandom, 0);
        end_session("t5");

        for (int s = 0; s < 6; s++) begin
            start_session(3'($urandom_range(0, 7)), $urandom_range(0, 40));
            nw = $urandom_range(1, 5);
            for (int w = 0; w < nw; w++) send_word($urandom, 0);
            end_session($sformatf("rnd%0d", s));
        end

        // Reset mid-word.
        start_session(3'b010, 100);
        bootdata = 32'hAABBCCDD;
        req      = 1'b1;
        wait_two_strobes("t6r");
        #1 reset = 1'b1;
        #1;
        check_reset("t6r async");
        rb       = ev_q.size();
        req      = 1'b0;
        download = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6r no wr after reset", 32'(ev_q.size()), 32'(rb));
        chk("t6r done held", 32'(done), 32'hF);

        // Download drop mid-word.
        start_session(3'b111, 100);
        bootdata = 32'hAABBCCDD;
        req      = 1'b1;
        wait_two_strobes("t6f");
        download = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6f done", 32'(done[0]), 32'd1);
        chk("t6f addr", 32'(addr[0]), 32'd2);
        chk("t6f dl", 32'(dlo[0]), 32'd0);
        chk("t6f ack", 32'(ack[0]), 32'd0);
        rb = 0;
        for (int i = ev_base; i < ev_q.size(); i++) if (ev_q[i].d == 0) rb++;
        chk("t6f d0 writes", 32'(rb), 32'd2);
        req = 1'b0;
        repeat (3) @(negedge clk);

        // Normal operation after an abort.
        start_session(3'b111, 7);
        send_word($urandom, 0);
        send_word($urandom, 0);
        end_session("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
